// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: bus widths, mem_ctl field
// positions, access-size codes and the stage state machine.
package mem_stage_pkg;

  localparam int EX2MEMBusSize = 108;
  localparam int MEM2WBBusSize = 70;

  localparam int MemLd     = 5;
  localparam int MemSt     = 4;
  localparam int MemSizeHi = 3;
  localparam int MemSizeLo = 2;
  localparam int MemUns    = 1;

  localparam logic [1:0] MemByte = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemWord = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } mem_state_e;

endpackage

// File: rtl/mem_stage_align.sv
// Lane steering for the data-memory port: store strobes/replicated write data
// and load lane extraction with sign or zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rdata,
  input  logic        i_uns,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  function automatic logic [31:0] ext8(input logic signed [7:0] b, input logic uns);
    return uns ? {24'b0, b} : 32'(b);
  endfunction

  function automatic logic [31:0] ext16(input logic signed [15:0] h, input logic uns);
    return uns ? {16'b0, h} : 32'(h);
  endfunction

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Size code 11 falls through to the word case.
  always_comb begin
    o_wstrb   = 4'b1111;
    o_wdata   = i_st_data;
    o_ld_data = i_rdata;
    case (i_size)
      MemByte: begin
        o_wstrb   = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_st_data[7:0]}};
        o_ld_data = ext8(w_byte, i_uns);
      end
      MemHalf: begin
        o_wstrb   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_st_data[15:0]}};
        o_ld_data = ext16(w_half, i_uns);
      end
      default: begin
        o_wstrb   = 4'b1111;
        o_wdata   = i_st_data;
        o_ld_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX->MEM register, runs one load/store at a
// time over a split request/response port and presents the result to WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EX2MEM_W = EX2MEMBusSize,
  parameter int MEM2WB_W = MEM2WBBusSize
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [EX2MEM_W-1:0] ex2mem_bus_i,
  input  logic                ctl_ex_over_i,
  output logic                ctl_mem_allowin_o,
  output logic [MEM2WB_W-1:0] mem2wb_bus_o,
  output logic                ctl_mem_over_o,
  input  logic                ctl_wb_allowin_i,
  output logic [4:0]          ctl_mem_dest_o,
  output logic [31:0]         ctl_mem_pc_o,
  output logic                data_req_o,
  output logic                data_wr_o,
  output logic [1:0]          data_size_o,
  output logic [31:0]         data_addr_o,
  output logic [3:0]          data_wstrb_o,
  output logic [31:0]         data_wdata_o,
  input  logic                data_addr_ok_i,
  input  logic                data_data_ok_i,
  input  logic [31:0]         data_rdata_i
);

  mem_state_e  r_state, w_state_nxt;
  logic [5:1]  r_ctl_p0;
  logic [31:0] r_st_data_p0;
  logic [31:0] r_exe_result_p0;
  logic [4:0]  r_rd_addr_p0;
  logic        r_rd_we_p0;
  logic [31:0] r_pc_p0;
  logic [31:0] r_wb_data_p0;

  logic        w_accept;
  logic        w_in_is_mem;
  logic        w_is_st;
  logic        w_is_ld;
  logic        w_data_fire;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic        w_unused_ctl0;

  assign w_unused_ctl0 = ex2mem_bus_i[102];

  assign w_in_is_mem = ex2mem_bus_i[102 + MemLd] | ex2mem_bus_i[102 + MemSt];
  assign w_is_st     = r_ctl_p0[MemSt];
  assign w_is_ld     = r_ctl_p0[MemLd] & ~r_ctl_p0[MemSt];

  assign ctl_mem_allowin_o = (r_state == ST_IDLE) |
                             ((r_state == ST_DONE) & ctl_wb_allowin_i);
  assign w_accept          = ctl_ex_over_i & ctl_mem_allowin_o;
  // Responses only count while a request has been (or is being) accepted.
  assign w_data_fire       = data_data_ok_i &
                             (((r_state == ST_REQ) & data_addr_ok_i) | (r_state == ST_WAIT));

  mem_align u_align (
    .i_size    (r_ctl_p0[MemSizeHi:MemSizeLo]),
    .i_addr_lo (r_exe_result_p0[1:0]),
    .i_st_data (r_st_data_p0),
    .i_rdata   (data_rdata_i),
    .i_uns     (r_ctl_p0[MemUns]),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata),
    .o_ld_data (w_ld_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_in_is_mem ? ST_REQ : ST_DONE;
      ST_REQ:  if (data_addr_ok_i) w_state_nxt = data_data_ok_i ? ST_DONE : ST_WAIT;
      ST_WAIT: if (data_data_ok_i) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_accept)              w_state_nxt = w_in_is_mem ? ST_REQ : ST_DONE;
        else if (ctl_wb_allowin_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: EX->MEM register and write-back data capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state         <= ST_IDLE;
      r_ctl_p0        <= '0;
      r_st_data_p0    <= '0;
      r_exe_result_p0 <= '0;
      r_rd_addr_p0    <= '0;
      r_rd_we_p0      <= 1'b0;
      r_pc_p0         <= '0;
      r_wb_data_p0    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ctl_p0        <= ex2mem_bus_i[107:103];
        r_st_data_p0    <= ex2mem_bus_i[101:70];
        r_exe_result_p0 <= ex2mem_bus_i[69:38];
        r_rd_addr_p0    <= ex2mem_bus_i[37:33];
        r_rd_we_p0      <= ex2mem_bus_i[32];
        r_pc_p0         <= ex2mem_bus_i[31:0];
        r_wb_data_p0    <= ex2mem_bus_i[69:38];
      end else if (w_data_fire && w_is_ld) begin
        r_wb_data_p0    <= w_ld_data;
      end
    end
  end

  always_comb begin
    data_req_o   = 1'b0;
    data_wr_o    = 1'b0;
    data_size_o  = 2'b00;
    data_addr_o  = '0;
    data_wstrb_o = 4'b0000;
    data_wdata_o = '0;
    if (r_state == ST_REQ) begin
      data_req_o  = 1'b1;
      data_wr_o   = w_is_st;
      data_size_o = r_ctl_p0[MemSizeHi:MemSizeLo];
      data_addr_o = r_exe_result_p0;
      if (w_is_st) begin
        data_wstrb_o = w_wstrb;
        data_wdata_o = w_wdata;
      end
    end
  end

  assign ctl_mem_over_o = (r_state == ST_DONE);
  assign ctl_mem_dest_o = ((r_state != ST_IDLE) && r_rd_we_p0) ? r_rd_addr_p0 : 5'd0;
  assign ctl_mem_pc_o   = r_pc_p0;
  assign mem2wb_bus_o   = {r_wb_data_p0, r_rd_addr_p0, r_rd_we_p0, r_pc_p0};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage directly downstream of the execute stage. It holds the EX→MEM pipeline register, performs loads and stores over a split request/response data-memory interface, and aligns and extends load data. It presents the write-back bus to the WB stage and uses the valid/over/allowin handshake of the rest of the pipeline.

## Interface

Parameters:
- `EX2MEM_W`, 108: `{mem_ctl[5:0], st_data[31:0], exe_result[31:0], rd_addr[4:0], rd_we, pc[31:0]}`, MSB first.
- `MEM2WB_W`, 70: `{wb_data[31:0], rd_addr[4:0], rd_we, pc[31:0]}`, MSB first.

Ports:
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `ex2mem_bus_i` in `EX2MEM_W`: EX result bundle.
- `ctl_ex_over_i` in 1: EX bundle is valid and complete this cycle.
- `ctl_mem_allowin_o` out 1: stage can accept a bundle this cycle.
- `mem2wb_bus_o` out `MEM2WB_W`: bundle for WB.
- `ctl_mem_over_o` out 1: `mem2wb_bus_o` is valid.
- `ctl_wb_allowin_i` in 1: WB accepts the bundle this cycle.
- `ctl_mem_dest_o` out 5: destination register for hazard detection. It is 0 when the stage is empty or `rd_we` is 0.
- `ctl_mem_pc_o` out 32: pc of the held instruction.
- `data_req_o` out 1; `data_wr_o` out 1; `data_size_o` out 2; `data_addr_o` out 32; `data_wstrb_o` out 4; `data_wdata_o` out 32: the request channel.
- `data_addr_ok_i` in 1; `data_data_ok_i` in 1; `data_rdata_i` in 32: the response channel.

## Operation

- `mem_ctl` bit fields:
  - [5] load
  - [4] store
  - [3:2] size: 00 byte, 01 half, 10 word; 11 is treated as word
  - [1] unsigned load
  - [0] ignored
- If [5] and [4] are both set, the operation is a store.
- States:
  - IDLE: empty.
  - REQ: request outstanding, waiting for `data_addr_ok_i`.
  - WAIT: waiting for `data_data_ok_i`.
  - DONE: result held for WB.
- Accept condition: `ctl_ex_over_i & ctl_mem_allowin_o`. On accept, the bundle is latched and the next state is REQ for a load or store, DONE otherwise.
- `ctl_mem_allowin_o = IDLE | (DONE & ctl_wb_allowin_i)`. This gives back-to-back throughput for non-memory ops.
- Request signals in REQ:
  - `data_req_o = 1`.
  - `data_addr_o = exe_result`.
  - `data_size_o = size`.
  - `data_wr_o = store`.
- Byte strobes and write data are lane-replicated:
  - byte: `wstrb = 4'b0001 << addr[1:0]`, `wdata = {4{st[7:0]}}`.
  - half: `wstrb = addr[1] ? 1100 : 0011`, `wdata = {2{st[15:0]}}`.
  - word: `wstrb = 1111`, `wdata = st`.
- Ignored address bits: `addr[0]` for half, `addr[1:0]` for word. There is no misalignment trap.
- Outside REQ: `data_req_o = 0` and `data_wstrb_o = 0`.
- Transitions:
  - REQ → WAIT on `addr_ok`.
  - REQ → DONE on `addr_ok & data_ok` in the same cycle.
  - WAIT → DONE on `data_ok`.
  - DONE → IDLE on `ctl_wb_allowin_i` with no new accept.
  - DONE → REQ or DONE when a new bundle is accepted in the same cycle.
- Load data capture: on `data_ok`, select the lane by `addr[1:0]` (byte) or `addr[1]` (half). Zero-extend if [1] is set, otherwise sign-extend. Register the result into `wb_data`.
- For stores and non-memory ops, `wb_data = exe_result`.
- `data_data_ok_i` is ignored in IDLE, REQ-without-`addr_ok`, and DONE, so stale responses are dropped.
- Reset: all state is cleared to IDLE. Every output is 0 except `ctl_mem_allowin_o = 1`.
- Reset mid-transaction abandons the access. The memory side must not return `data_ok` for it after reset deasserts. This is a system requirement, not checked here.

## Timing

- Non-memory op: accepted at edge N; `ctl_mem_over_o` is 1 in cycle N+1. One cycle of latency.
- Memory op, zero-wait memory (`addr_ok` in the first REQ cycle, `data_ok` the cycle after): over in cycle N+3. `data_ok` in the same cycle as `addr_ok` gives N+2.
- `data_req_o` and all request fields stay stable from entering REQ until `addr_ok` is seen.
- `mem2wb_bus_o`, `ctl_mem_dest_o` and `ctl_mem_pc_o` are registered outputs, stable for the whole DONE state.
- At most one outstanding memory transaction.

## Structure

- `common.vh` gains the following:
  - `EX2MEMBusSize`
  - `MEM2WBBusSize`
  - `mem_ctl` bit-index macros: `MemLd`, `MemSt`, `MemSizeHi`, `MemSizeLo`, `MemUns`
  - size encodings: `MemByte`, `MemHalf`, `MemWord`
  - state encodings for this block
- One sub-module, `mem_align`, combinational. It generates `wstrb`/`wdata` from size, address and store data, and extracts and extends load data.

## Test plan

- ALU op (`mem_ctl = 0`, result 0x1234, rd 5, we 1), WB always allowin → over in cycle +1; bus carries `wb_data = 0x1234`; `ctl_mem_dest_o = 5`.
- Byte store, addr 0x1002, `st_data = 0x…AB` → request `wstrb = 0100`, `wdata = 0xABABABAB`, `wr = 1`; over after `data_ok`.
- Signed byte load, addr 0x1003, `rdata = 0x80FF_0000` → `wb_data = 0xFFFF_FF80`. The same access unsigned → `0x0000_0080`. Half load at addr 0x1002 with `rdata = 0x8001_xxxx` (signed) → `0xFFFF_8001`.
- `addr_ok` held low for 3 cycles, then `addr_ok` and `data_ok` together → request fields stable across all 4 cycles; DONE entered directly.
- WB allowin low for 2 cycles in DONE with EX over asserted → `allowin = 0`, bus held. When allowin rises, the next bundle is accepted the same cycle with no bubble.
- `rst_n_i` asserted in WAIT, then a late `data_ok` pulse after release → outputs at reset values, state IDLE, pulse ignored, no over.
